// File: rtl/bit_packer.sv
`default_nettype none
// ============================================================================
// Module      : bit_packer
// Description : Packs variable-length fields (0..15 bits) MSB-first into
//               32-bit words, buffered in a show-ahead output FIFO with
//               valid/stall flow control. Flush emits a left-aligned,
//               zero-padded partial word.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_packer #(
    parameter int ODEPTH = 4,
    parameter int OAW    = 2
) (
    input  logic        clock,
    input  logic        RstN,
    input  logic        pushin,
    input  logic [3:0]  lenin,
    input  logic [14:0] datain,
    input  logic        flush,
    output logic        stall,
    output logic        pushout,
    output logic [31:0] dataout,
    output logic [5:0]  bitsout,
    input  logic        stallin
);

    localparam logic [OAW:0]   c_full_count = (OAW+1)'(ODEPTH);
    localparam logic [OAW:0]   c_cnt_one    = (OAW+1)'(1);
    localparam logic [OAW-1:0] c_ptr_one    = OAW'(1);

    // Accumulator: left-aligned bits plus a count of valid bits (0..31)
    logic [31:0]    r_acc;
    logic [4:0]     r_acc_bits;
    logic           r_flush_pending;

    // Output FIFO: each entry holds {word, valid bit count}
    logic [37:0]    r_mem [ODEPTH];
    logic [OAW-1:0] r_wptr;
    logic [OAW-1:0] r_rptr;
    logic [OAW:0]   r_count;

    logic [14:0]    w_mask;
    logic [14:0]    w_field;
    logic [5:0]     w_total;
    logic [6:0]     w_shamt;
    logic [63:0]    w_wide;
    logic           w_accept;
    logic           w_flush_req;
    logic           w_do_flush;
    logic           w_wr;
    logic           w_rd;
    logic [37:0]    w_wr_data;
    logic [37:0]    w_head;

    assign stall   = (r_count == c_full_count);
    assign pushout = (r_count != '0);
    assign w_rd    = pushout & ~stallin;

    // Field masking, append position and word/flush write decisions
    always_comb begin
        w_mask      = ~(15'h7FFF << lenin);
        w_field     = datain & w_mask;
        w_accept    = pushin & ~stall & (lenin != 4'd0);
        // Six bits wide: 31 + 15 = 46 must not wrap
        w_total     = {1'b0, r_acc_bits} + {2'b00, lenin};
        // Shift that lands the field MSB at bit (63 - acc_bits) of a 64-bit window
        w_shamt     = 7'd64 - {1'b0, w_total};
        w_wide      = {r_acc, 32'h0} | ({49'h0, w_field} << w_shamt);
        w_flush_req = flush | r_flush_pending;
        w_do_flush  = w_flush_req & ~w_accept & ~stall;
        w_wr        = (w_accept & w_total[5]) | (w_do_flush & (r_acc_bits != 5'd0));
        w_wr_data   = w_accept ? {w_wide[63:32], 6'd32}
                               : {r_acc, 1'b0, r_acc_bits};
    end

    // Accumulator, pending-flush flag and FIFO pointers/occupancy
    always_ff @(posedge clock or posedge RstN) begin
        if (RstN) begin
            r_acc           <= '0;
            r_acc_bits      <= '0;
            r_flush_pending <= 1'b0;
            r_wptr          <= '0;
            r_rptr          <= '0;
            r_count         <= '0;
        end else begin
            if (w_accept) begin
                // Bits past a completed word stay left-aligned in the low half
                r_acc      <= w_total[5] ? w_wide[31:0] : w_wide[63:32];
                r_acc_bits <= w_total[4:0];
            end else if (w_do_flush) begin
                r_acc      <= '0;
                r_acc_bits <= '0;
            end
            r_flush_pending <= w_flush_req & ~w_do_flush;
            if (w_wr) r_wptr <= r_wptr + c_ptr_one;
            if (w_rd) r_rptr <= r_rptr + c_ptr_one;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; contents are don't-care while the entry is not counted
    always_ff @(posedge clock) begin
        if (w_wr) r_mem[r_wptr] <= w_wr_data;
    end

    // Show-ahead head entry, forced to zero when the buffer is empty
    always_comb begin
        w_head  = r_mem[r_rptr];
        dataout = pushout ? w_head[37:6] : 32'h0;
        bitsout = pushout ? w_head[5:0]  : 6'd0;
    end

endmodule
`default_nettype wire

// File: tb/tb_bit_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bit_packer
// Description : Directed self-checking bench for bit_packer with a queue of
//               expected output words popped as the DUT hands words out.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bit_packer;

    logic        clock = 1'b0;
    logic        RstN;
    logic        pushin;
    logic [3:0]  lenin;
    logic [14:0] datain;
    logic        flush;
    logic        stall;
    logic        pushout;
    logic [31:0] dataout;
    logic [5:0]  bitsout;
    logic        stallin;

    int n_checks = 0;
    int n_fail   = 0;
    logic [37:0] exp_q [$];

    bit_packer #(.ODEPTH(4), .OAW(2)) dut (
        .clock   (clock),
        .RstN    (RstN),
        .pushin  (pushin),
        .lenin   (lenin),
        .datain  (datain),
        .flush   (flush),
        .stall   (stall),
        .pushout (pushout),
        .dataout (dataout),
        .bitsout (bitsout),
        .stallin (stallin)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Scoreboard: every word popped by downstream must match the queue head
    always @(negedge clock) begin
        if (!RstN && pushout && !stallin) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", {26'h0, dataout, bitsout}, 64'h0);
            end else begin
                logic [37:0] e;
                e = exp_q.pop_front();
                check("word_data", {32'h0, dataout}, {32'h0, e[37:6]});
                check("word_bits", {58'h0, bitsout}, {58'h0, e[5:0]});
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [3:0] l, input logic [14:0] d);
        pushin = 1'b1;
        lenin  = l;
        datain = d;
        tick();
        pushin = 1'b0;
        lenin  = 4'd0;
        datain = 15'h0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0 && !pushout) break;
            tick();
        end
        check(tag, {32'h0, exp_q.size()}, 64'h0);
        check({tag, "_idle"}, {63'h0, pushout}, 64'h0);
    endtask

    initial begin
        RstN    = 1'b1;
        pushin  = 1'b0;
        lenin   = 4'd0;
        datain  = 15'h0;
        flush   = 1'b0;
        stallin = 1'b0;
        tick();
        tick();
        RstN = 1'b0;
        check("rst_pushout", {63'h0, pushout}, 64'h0);
        check("rst_stall",   {63'h0, stall},   64'h0);
        check("rst_dataout", {32'h0, dataout}, 64'h0);
        check("rst_bitsout", {58'h0, bitsout}, 64'h0);

        // 32 single-bit fields 1,0,1,0,... form one 0xAAAAAAAA word
        exp_q.push_back({32'hAAAAAAAA, 6'd32});
        for (int i = 0; i < 32; i++) push(4'd1, (i % 2 == 0) ? 15'h1 : 15'h0);
        check("alt_pushout_hi", {63'h0, pushout}, 64'h1);
        tick();
        check("alt_pushout_lo", {63'h0, pushout}, 64'h0);

        // Word straddle plus two-bit flushed remainder
        exp_q.push_back({32'hFFFE0003, 6'd32});
        exp_q.push_back({32'hC0000000, 6'd2});
        push(4'd15, 15'h7FFF);
        push(4'd15, 15'h0000);
        push(4'd4,  15'h000F);
        do_flush();
        drain("straddle_drain");

        // Upper datain bits masked; zero-length push is a no-op
        exp_q.push_back({32'hA0000000, 6'd3});
        push(4'd3, 15'h7FFD);
        push(4'd0, 15'h7FFF);
        do_flush();
        drain("mask_drain");
        do_flush();
        tick();
        check("empty_flush_noword", {63'h0, pushout}, 64'h0);

        // Fill the buffer under downstream hold, then drain in order
        stallin = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back({32'h55555555, 6'd32});
        for (int i = 0; i < 32; i++) push(4'd4, 15'h5);
        check("full_stall",   {63'h0, stall},   64'h1);
        check("full_head",    {32'h0, dataout}, {32'h0, 32'h55555555});
        push(4'd4, 15'hF);
        check("dropped_stall", {63'h0, stall},  64'h1);
        stallin = 1'b0;
        check("stall_at_pop", {63'h0, stall},   64'h1);
        tick();
        check("stall_after_pop", {63'h0, stall}, 64'h0);
        drain("full_drain");
        do_flush();
        tick();
        check("dropped_push_noword", {63'h0, pushout}, 64'h0);

        // Push completing a word together with flush: full word, then partial
        exp_q.push_back({32'h00000003, 6'd32});
        exp_q.push_back({32'hC0000000, 6'd2});
        push(4'd15, 15'h0);
        push(4'd15, 15'h0);
        pushin = 1'b1;
        lenin  = 4'd4;
        datain = 15'hF;
        flush  = 1'b1;
        tick();
        pushin = 1'b0;
        flush  = 1'b0;
        check("pf_first_bits", {58'h0, bitsout}, 64'd32);
        drain("pf_drain");

        // Asynchronous reset mid-operation discards words and partial bits
        stallin = 1'b1;
        for (int i = 0; i < 21; i++) push(4'd4, 15'hF);
        check("pre_rst_stall", {63'h0, stall},   64'h0);
        check("pre_rst_head",  {32'h0, dataout}, {32'h0, 32'hFFFFFFFF});
        #3;
        RstN = 1'b1;
        #1;
        check("async_pushout", {63'h0, pushout}, 64'h0);
        check("async_stall",   {63'h0, stall},   64'h0);
        check("async_dataout", {32'h0, dataout}, 64'h0);
        tick();
        RstN    = 1'b0;
        stallin = 1'b0;
        exp_q.push_back({32'h11111111, 6'd32});
        for (int i = 0; i < 8; i++) push(4'd4, 15'h1);
        drain("post_rst_drain");
        do_flush();
        tick();
        check("post_rst_acc_empty", {63'h0, pushout}, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bit_packer.md
Name: bit_packer

Overview:
- Packs a stream of variable-length bit fields, 0 to 15 bits each, MSB-first into 32-bit words.
- Hands completed words downstream through a small show-ahead output buffer with valid/stall flow control.
- It is the write-side counterpart of the bits unpacker: a word stream produced here and fed to the unpacker with the same reqlen sequence returns the original fields.
- A flush control emits a final partial word, left-aligned and zero-padded.

Parameters:
- ODEPTH, 4: output buffer depth in words; must be a power of two, minimum 2.
- OAW, 2: output buffer pointer width; log2(ODEPTH).

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- RstN  input  1  reset, asynchronous, active-high (despite the N suffix).
- pushin  input  1  field valid; ignored while stall=1.
- lenin  input  4  field length in bits, 0..15; 0 is a no-op.
- datain  input  15  field value in datain[lenin-1:0]; bits at or above lenin are ignored (masked).
- flush  input  1  request to emit any partial word.
- stall  output  1  upstream must not push; combinational, equals (out_count == ODEPTH).
- pushout  output  1  dataout/bitsout valid; equals (out_count != 0).
- dataout  output  32  head word; first packed bit at dataout[31].
- bitsout  output  6  number of valid bits in dataout: 32 for full words, 1..31 for flushed words.
- stallin  input  1  downstream hold; a word is popped in any cycle where pushout=1 and stallin=0.

Behaviour:
- Reset (async, RstN=1):
  - Accumulator is cleared; acc_bits=0.
  - Buffer pointers and out_count are 0; flush_pending=0.
  - Outputs: pushout=0, stall=0, dataout=0, bitsout=0.
  - Reset mid-operation discards all accumulated bits and buffered words.
- Accumulator:
  - 32-bit left-aligned register plus acc_bits (0..31).
  - An accepted push (pushin=1, stall=0, lenin>0) appends the field at bit position 31-acc_bits downward; new total is acc_bits+lenin.
  - If the total is 32 or more: write the 32-bit word (bitsout=32) into the buffer on the same edge. The overflow bits (total-32, at most 14) become the new accumulator top bits, acc_bits=total-32, and the remaining bits are zeroed.
  - Otherwise acc_bits=total.
  - An accepted push completes at most one word.
- Output buffer:
  - Show-ahead FIFO; dataout/bitsout always reflect the head entry.
  - When empty, dataout=0 and bitsout=0.
  - Write and pop may occur in the same cycle; out_count is then unchanged.
  - Pointers wrap modulo ODEPTH.
- Latency: a word completed at edge N is visible with pushout=1 from cycle N+1 when the buffer was empty.
- Stall:
  - stall depends only on out_count; a pop in the same cycle does not lower it (conservative).
  - pushin while stall=1 is dropped with no state change; preventing this is upstream's responsibility.
- Flush:
  - A flush is acted on only in a cycle with no accepted push and stall=0.
  - When acted on with acc_bits>0: the accumulator is written to the buffer with bitsout=acc_bits and low bits zero; acc_bits becomes 0.
  - When acted on with acc_bits=0: no word is written.
  - flush asserted with an accepted push, or while stall=1, sets flush_pending. The pending flush executes in the first later cycle that meets the conditions above.
  - flush_pending clears when the flush executes.
  - Further flush pulses while pending are merged into the one pending flush.
- Simultaneous events:
  - Push and flush in the same cycle: the push is applied first; its full word, if any, is written this edge and the flush follows next cycle.
  - Push completing a word while the buffer is full cannot occur: stall prevents acceptance.
- Arithmetic: the total is computed 6 bits wide (max 31+15=46); no silent truncation is permitted.

Test Plan:
- 32 pushes, lenin=1, datain alternating 1,0; stallin=0 -> one word dataout=0xAAAAAAAA, bitsout=32, pushout high exactly 1 cycle.
- Push (15,0x7FFF), (15,0x0000), (4,0xF), then flush -> first word 0xFFFE0003 with bitsout=32, then 0xC0000000 with bitsout=2.
- Push lenin=3, datain=0x7FFD (garbage upper bits), then flush -> 0xA0000000, bitsout=3. Push lenin=0 -> no state change.
- stallin=1; push 8 fields of 16 bits (lenin=15 cannot give 16: use 32 pushes of lenin=4, datain=0x5) -> 4 words of 0x55555555; stall=1 after the 4th; a further pushin is dropped. Release stallin -> words drain in order, stall falls the cycle after the first pop.
- Accumulate 30 bits, then in one cycle push lenin=4, datain=0xF with flush=1 -> word with bitsout=32 at that edge, then a partial word 0xC0000000 with bitsout=2 the next cycle.
- 20 bits accumulated and 2 words buffered; pulse RstN mid-cycle -> pushout=0 and stall=0 immediately. Then 8 pushes of (4,0x1) -> dataout=0x11111111, proving no stale bits remain.
